// File: rtl/rt_ctrl_master.sv
// rtl/rt_ctrl_master.sv - Avalon-MM master that starts a raytrace job, waits for irq, reads status
module rt_ctrl_master #(
    parameter logic [7:0]  CMD_WORD    = 8'h01,
    parameter int          RD_LATENCY  = 1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd16777216
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic [7:0] status,
    output logic       timed_out,
    output logic       avm_m0_write,
    output logic       avm_m0_read,
    output logic [7:0] avm_m0_writedata,
    input  logic [7:0] avm_m0_readdata,
    input  logic       avm_m0_waitrequest,
    input  logic       irq
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_IRQ,
        READ,
        LAT,
        DONE
    } state_t;

    // Last LAT cycle index: readdata is valid RD_LATENCY cycles after the read is accepted (1..4).
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_lat;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_status;
    logic        r_timed_out;
    logic        r_write;
    logic        r_read;
    logic [7:0]  r_wdata;

    // Terminal count of the irq wait; a zero timeout disables abandoning the job.
    logic w_tc;
    assign w_tc = (TIMEOUT_CYC != 32'd0) && (r_cnt == (TIMEOUT_CYC - 32'd1));

    // Job sequencer: every output is produced directly from a register of this FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 32'd0;
            r_lat       <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= 8'd0;
            r_timed_out <= 1'b0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_wdata     <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_state <= WRITE;
                        r_busy  <= 1'b1;
                        r_write <= 1'b1;
                        r_wdata <= CMD_WORD;
                    end
                end
                WRITE: begin
                    // Strobe stays up until the slave takes it.
                    if (!avm_m0_waitrequest) begin
                        r_state <= WAIT_IRQ;
                        r_write <= 1'b0;
                        r_wdata <= 8'd0;
                        r_cnt   <= 32'd0;
                    end
                end
                WAIT_IRQ: begin
                    // irq wins over the terminal count; a stale high irq completes at once.
                    if (irq) begin
                        r_state <= READ;
                        r_read  <= 1'b1;
                    end else if (w_tc) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                READ: begin
                    if (!avm_m0_waitrequest) begin
                        r_state <= LAT;
                        r_read  <= 1'b0;
                        r_lat   <= 3'd1;
                    end
                end
                LAT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state     <= DONE;
                        r_status    <= avm_m0_readdata;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b0;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                DONE: begin
                    // go is deliberately ignored here; it is only taken in IDLE.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign status           = r_status;
    assign timed_out        = r_timed_out;
    assign avm_m0_write     = r_write;
    assign avm_m0_read      = r_read;
    assign avm_m0_writedata = r_wdata;

endmodule

// File: tb/tb_rt_ctrl_master.sv
// tb/tb_rt_ctrl_master.sv - self-checking bench for rt_ctrl_master against a cycle-count reference model
module tb_rt_ctrl_master;

    localparam logic [7:0] CMD = 8'h01;
    localparam int         RDL = 3;
    localparam int         TO  = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       go = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] status;
    logic       timed_out;
    logic       avm_m0_write;
    logic       avm_m0_read;
    logic [7:0] avm_m0_writedata;
    logic [7:0] avm_m0_readdata = 8'd0;
    logic       avm_m0_waitrequest = 1'b0;
    logic       irq = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_status = 8'd0;

    always #5 clk = ~clk;

    rt_ctrl_master #(
        .CMD_WORD    (CMD),
        .RD_LATENCY  (RDL),
        .TIMEOUT_CYC (32'(TO))
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .go                 (go),
        .busy               (busy),
        .done               (done),
        .status             (status),
        .timed_out          (timed_out),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_read        (avm_m0_read),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_readdata    (avm_m0_readdata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .irq                (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_to"},    32'(timed_out), 32'd0);
        check({tag, "_write"}, 32'(avm_m0_write), 32'd0);
        check({tag, "_read"},  32'(avm_m0_read), 32'd0);
        check({tag, "_stat"},  32'(status), 32'd0);
        check({tag, "_wdata"}, 32'(avm_m0_writedata), 32'd0);
    endtask

    // One job: slave stalls the write ws cycles and the read rs cycles, raises irq irq_dly
    // cycles after the write is accepted (negative = never), readdata is random every cycle.
    task automatic run_job(input int ws, input int rs, input int irq_dly, input bit go_in_done);
        int cyc, wacc, racc, dcyc, wcnt, rcnt, wst, rst, seen, exp_racc;
        bit irq_pre, exp_to;
        logic [7:0] hist[$];
        cyc = 0; wacc = -1; racc = -1; dcyc = -1; wcnt = 0; rcnt = 0; wst = ws; rst = rs;
        irq_pre = irq;
        exp_to = !(irq_pre || (irq_dly >= 0 && irq_dly <= TO));
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        while (cyc < 400) begin
            avm_m0_readdata = 8'($urandom);
            hist.push_back(avm_m0_readdata);
            check("excl", 32'(avm_m0_write & avm_m0_read), 32'd0);
            check("wdata", 32'(avm_m0_writedata), avm_m0_write ? 32'(CMD) : 32'd0);
            if (avm_m0_write) begin
                wcnt++;
                if (wst > 0) begin avm_m0_waitrequest = 1'b1; wst--; end
                else begin avm_m0_waitrequest = 1'b0; wacc = cyc; end
            end else if (avm_m0_read) begin
                rcnt++;
                if (rst > 0) begin avm_m0_waitrequest = 1'b1; rst--; end
                else begin avm_m0_waitrequest = 1'b0; racc = cyc; irq = 1'b0; end
            end else begin
                avm_m0_waitrequest = 1'($urandom);
            end
            if (wacc >= 0 && irq_dly >= 0 && cyc == wacc + irq_dly) irq = 1'b1;
            if (done) begin
                dcyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
                if (go_in_done) go = 1'b1;
                break;
            end
            check("busy_in_job", 32'(busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(dcyc >= 0), 32'd1);
        check("wr_cycles", 32'(wcnt), 32'(ws + 1));
        check("wr_accept", 32'(wacc), 32'(ws));
        if (exp_to) begin
            check("rd_cycles_to", 32'(rcnt), 32'd0);
            check("to_cycle", 32'(dcyc), 32'(ws + 1 + TO));
            check("to_flag", 32'(timed_out), 32'd1);
            check("to_status", 32'(status), 32'(exp_status));
        end else begin
            seen = irq_pre ? wacc + 1 : ((irq_dly > 1) ? wacc + irq_dly : wacc + 1);
            exp_racc = seen + 1 + rs;
            check("rd_accept", 32'(racc), 32'(exp_racc));
            check("rd_cycles", 32'(rcnt), 32'(rs + 1));
            check("done_cycle", 32'(dcyc), 32'(exp_racc + RDL + 1));
            if (exp_racc + RDL < hist.size()) exp_status = hist[exp_racc + RDL];
            check("status", 32'(status), 32'(exp_status));
            check("to_flag", 32'(timed_out), 32'd0);
        end
        @(negedge clk); go = 1'b0;
        repeat (4) begin
            check("post_busy", 32'(busy), 32'd0);
            check("post_done", 32'(done), 32'd0);
            check("post_write", 32'(avm_m0_write), 32'd0);
            check("post_status", 32'(status), 32'(exp_status));
            @(negedge clk);
        end
    endtask

    // Start a job, let it run into a write stall (stall=1) or WAIT_IRQ (stall=0), then reset.
    task automatic reset_mid(input bit stall, input int cycles);
        irq = 1'b0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        avm_m0_waitrequest = stall;
        repeat (cycles) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_write", 32'(avm_m0_write), 32'(stall));
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge clk); reset_n = 1'b1;
        avm_m0_waitrequest = 1'b0;
        exp_status = 8'd0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_job(0, 0, 10, 1'b0);
        run_job(3, 2, 10, 1'b1);
        run_job(0, 0, -1, 1'b0);
        run_job(1, 0, 100, 1'b0);
        run_job(0, 1, 101, 1'b0);
        run_job(2, 1, -1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 120)), 1'($urandom));
        end
        reset_mid(1'b0, 5);
        reset_mid(1'b1, 3);
        run_job(0, 0, 5, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rt_ctrl_master.md
RT_CTRL_MASTER -- requirements
Module: rt_ctrl_master

Interface
REQ-001 Parameter CMD_WORD, default 8'h01; data byte written to the control slave to start a raytrace.
REQ-002 Parameter RD_LATENCY, default 1; fixed slave read latency in cycles, legal range 1..4.
REQ-003 Parameter TIMEOUT_CYC, default 32'd16777216; cycles to wait for irq before abandoning the job; 0 = wait forever.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  request to start one job; sampled only in IDLE.
REQ-007 busy  out  1  high from the cycle after go is accepted until the cycle done pulses.
REQ-008 done  out  1  one-cycle pulse at job completion or timeout.
REQ-009 status  out  8  status byte read from the slave; held until the next done.
REQ-010 timed_out  out  1  valid with done; high when the job ended by timeout; held until the next done.
REQ-011 avm_m0_write  out  1  Avalon-MM write strobe.
REQ-012 avm_m0_read  out  1  Avalon-MM read strobe.
REQ-013 avm_m0_writedata  out  8  write data; equals CMD_WORD while write is high, 0 otherwise.
REQ-014 avm_m0_readdata  in  8  read data from the slave.
REQ-015 avm_m0_waitrequest  in  1  slave stall; a read or write transfers only in a cycle where waitrequest is low.
REQ-016 irq  in  1  level interrupt from the slave; high means status is ready.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, WAIT_IRQ, READ, LAT, DONE.
REQ-018 IDLE: go=1 -> WRITE next cycle; go=0 -> stay in IDLE.
REQ-019 WRITE: avm_m0_write=1 (registered); hold it while waitrequest=1; in the first cycle with waitrequest=0 the transfer completes and the next state is WAIT_IRQ.
REQ-020 WAIT_IRQ: a 32-bit counter clears on entry and increments each cycle; irq=1 -> READ; counter reaching TIMEOUT_CYC-1 with irq=0 and TIMEOUT_CYC!=0 -> DONE with timed_out=1 and status unchanged.
REQ-021 irq=1 in the same cycle as the timeout terminal count SHALL take priority: go to READ, no timeout.
REQ-022 irq that is already high on entry to WAIT_IRQ (stale from an earlier job) SHALL be accepted as completion.
REQ-023 READ: avm_m0_read=1; hold it while waitrequest=1; in the first cycle with waitrequest=0 the read is accepted and the next state is LAT.
REQ-024 LAT: count RD_LATENCY cycles from read acceptance; capture avm_m0_readdata into status on the RD_LATENCY-th cycle after acceptance -> DONE with timed_out=0.
REQ-025 DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
REQ-026 go=1 during DONE SHALL be ignored; go is only accepted in IDLE, the cycle after DONE.
REQ-027 read and write SHALL never be high in the same cycle; each job produces exactly one write and, unless it times out, exactly one read.
REQ-028 All outputs SHALL be registered; busy=1 in every state other than IDLE and DONE.

Reset
REQ-029 When reset_n=0, the block SHALL immediately, and asynchronously: go to IDLE; drive busy, done, timed_out, avm_m0_write and avm_m0_read to 0; clear status, avm_m0_writedata and the counters to 0.
REQ-030 Reset asserted mid-transfer SHALL drop any active strobe at once; a job in progress is lost and done is not generated for it.
REQ-031 The first go SHALL be accepted no earlier than the first rising edge after reset_n goes high.

Verification
REQ-032 Scenario: reset, go pulse, waitrequest=0, irq 10 cycles after the write, readdata=8'hA5 -> one write of 8'h01, one read, done pulse, status=8'hA5, timed_out=0.
REQ-033 Scenario: waitrequest held 3 cycles during the write and 2 cycles during the read -> each strobe is held exactly 4 and 3 cycles; the result is the same as in REQ-032.
REQ-034 Scenario: TIMEOUT_CYC=100, irq never rises -> done exactly 100 cycles after WAIT_IRQ is entered, timed_out=1, status keeps its prior value, no read issued.
REQ-035 Scenario: TIMEOUT_CYC=100, irq rises on the terminal-count cycle -> read is issued, timed_out=0.
REQ-036 Scenario: RD_LATENCY=3, readdata changes every cycle -> status equals the value present on the 3rd cycle after read acceptance.
REQ-037 Scenario: reset_n pulsed low during WAIT_IRQ and again while write is stalled -> all outputs go to 0 immediately, no done pulse, and the next go runs a clean job.
